// File: rtl/mux_sel_ctrl_pkg.sv
// Shared Basys3 board-input constants: debounce state encoding, default timing
// parameters and the counter-width helper used by the board-input blocks.
package mux_sel_ctrl_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEFAULT_AUTO_PERIOD     = 32'd50000000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_e;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_sel_ctrl_if.sv
// Board-side bundle of the select controller: raw inputs in, select and status out.
interface mux_sel_ctrl_if;

    logic btn;
    logic auto_en;
    logic sel;
    logic sel_pulse;
    logic btn_db;

    modport master (
        output btn,
        output auto_en,
        input  sel,
        input  sel_pulse,
        input  btn_db
    );

    modport slave (
        input  btn,
        input  auto_en,
        output sel,
        output sel_pulse,
        output btn_db
    );

endinterface

// File: rtl/mux_sel_ctrl_btn_debounce.sv
// Two-flop synchronizer plus four-state debounce FSM for a bouncing pushbutton.
module btn_debounce
    import mux_sel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic          sync_1_r;
    logic          sync_2_r;
    db_state_e     state_r;
    logic [CW-1:0] cnt_r;
    logic          btn_db_r;

    // Synchronizer: the only flops that see the raw button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
        end else begin
            sync_1_r <= btn;
            sync_2_r <= sync_1_r;
        end
    end

    // Debounce FSM; btn_db is registered alongside the state it decodes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= STABLE_LO;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b0;
        end else begin
            case (state_r)
                STABLE_LO: begin
                    cnt_r    <= CNT_ZERO;
                    btn_db_r <= 1'b0;
                    if (sync_2_r) begin
                        state_r <= WAIT_HI;
                    end else begin
                        state_r <= STABLE_LO;
                    end
                end
                WAIT_HI: begin
                    if (!sync_2_r) begin
                        state_r  <= STABLE_LO;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= STABLE_HI;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b1;
                    end else begin
                        state_r  <= WAIT_HI;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b0;
                    end
                end
                STABLE_HI: begin
                    cnt_r    <= CNT_ZERO;
                    btn_db_r <= 1'b1;
                    if (!sync_2_r) begin
                        state_r <= WAIT_LO;
                    end else begin
                        state_r <= STABLE_HI;
                    end
                end
                WAIT_LO: begin
                    // A return to high is a glitch: fall back without releasing btn_db.
                    if (sync_2_r) begin
                        state_r  <= STABLE_HI;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= STABLE_LO;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b0;
                    end else begin
                        state_r  <= WAIT_LO;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= STABLE_LO;
                    cnt_r    <= CNT_ZERO;
                    btn_db_r <= 1'b0;
                end
            endcase
        end
    end

    assign btn_db = btn_db_r;

endmodule

// File: rtl/mux_sel_ctrl.sv
// 2:1 mux select controller: debounced button toggles plus optional periodic auto-toggle.
module mux_sel_ctrl
    import mux_sel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned AUTO_PERIOD     = DEFAULT_AUTO_PERIOD
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_sel_ctrl_if.slave bus
);

    localparam int unsigned   AW        = cnt_width(AUTO_PERIOD);
    localparam logic [AW-1:0] AUTO_ZERO = AW'(32'd0);
    localparam logic [AW-1:0] AUTO_ONE  = AW'(32'd1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 32'd1);

    logic          btn_db_s;
    logic          btn_db_d_r;
    logic          auto_sync_1_r;
    logic          auto_sync_2_r;
    logic [AW-1:0] auto_cnt_r;
    logic          sel_r;
    logic          sel_pulse_r;
    logic          btn_req_s;
    logic          auto_req_s;
    logic          toggle_req_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (bus.btn),
        .btn_db (btn_db_s)
    );

    // Synchronizer for the slide switch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_sync_1_r <= 1'b0;
            auto_sync_2_r <= 1'b0;
        end else begin
            auto_sync_1_r <= bus.auto_en;
            auto_sync_2_r <= auto_sync_1_r;
        end
    end

    // Toggle requests: btn_db rising edge or auto-period wrap; both merge into one.
    always_comb begin
        btn_req_s    = btn_db_s & ~btn_db_d_r;
        auto_req_s   = auto_sync_2_r & (auto_cnt_r == AUTO_LAST);
        toggle_req_s = btn_req_s | auto_req_s;
    end

    // Auto period counter; any toggle restarts a full period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt_r <= AUTO_ZERO;
        end else if (!auto_sync_2_r) begin
            auto_cnt_r <= AUTO_ZERO;
        end else if (toggle_req_s) begin
            auto_cnt_r <= AUTO_ZERO;
        end else begin
            auto_cnt_r <= auto_cnt_r + AUTO_ONE;
        end
    end

    // Select register, its change strobe and the btn_db edge-detect history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_r       <= 1'b0;
            sel_pulse_r <= 1'b0;
            btn_db_d_r  <= 1'b0;
        end else begin
            sel_r       <= sel_r ^ toggle_req_s;
            sel_pulse_r <= toggle_req_s;
            btn_db_d_r  <= btn_db_s;
        end
    end

    assign bus.sel       = sel_r;
    assign bus.sel_pulse = sel_pulse_r;
    assign bus.btn_db    = btn_db_s;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_mux_sel_ctrl;

    localparam int DB = 4;
    localparam int AP = 8;

    logic clk = 1'b0;
    logic rst_n;
    mux_sel_ctrl_if bus();

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (AP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: synchronizer pipes, debounced level, disagreement run length,
    // cycles since the last auto restart, select and strobe.
    bit m_b1 = 0, m_b2 = 0, m_a1 = 0, m_a2 = 0;
    bit m_db = 0, m_dbp = 0, m_sel = 0, m_pulse = 0;
    int m_run = 0, m_acnt = 0;

    int first_db, first_mdb, first_p, second_p, npulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, computed from pre-edge values.
    task automatic model_step(input bit b, input bit a, input bit r);
        bit breq, areq, ndb;
        int nrun, nacnt;
        if (!r) begin
            m_b1 = 0; m_b2 = 0; m_a1 = 0; m_a2 = 0;
            m_db = 0; m_dbp = 0; m_sel = 0; m_pulse = 0;
            m_run = 0; m_acnt = 0;
        end else begin
            breq  = m_db && !m_dbp;
            areq  = m_a2 && (m_acnt == AP - 1);
            nacnt = (!m_a2 || breq || areq) ? 0 : m_acnt + 1;
            ndb   = m_db;
            nrun  = 0;
            if (m_b2 != m_db) begin
                nrun = m_run + 1;
                if (nrun == DB + 1) begin
                    ndb  = !m_db;
                    nrun = 0;
                end
            end
            m_pulse = breq || areq;
            m_sel   = m_sel ^ (breq || areq);
            m_acnt  = nacnt;
            m_dbp   = m_db;
            m_db    = ndb;
            m_run   = nrun;
            m_b2 = m_b1; m_b1 = b;
            m_a2 = m_a1; m_a1 = a;
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input bit b, input bit a, input bit r);
        bus.btn     = b;
        bus.auto_en = a;
        rst_n       = r;
        @(posedge clk);
        model_step(b, a, r);
        @(negedge clk);
        check("sel", bus.sel, 32'(m_sel));
        check("sel_pulse", bus.sel_pulse, 32'(m_pulse));
        check("btn_db", bus.btn_db, 32'(m_db));
    endtask

    task automatic clear_obs();
        first_db = -1; first_mdb = -1; first_p = -1; second_p = -1; npulse = 0;
    endtask

    task automatic observe(input int idx);
        if (bus.btn_db === 1'b1 && first_db < 0) first_db = idx;
        if (m_db && first_mdb < 0) first_mdb = idx;
        if (bus.sel_pulse === 1'b1) begin
            npulse++;
            if (first_p < 0) first_p = idx;
            else if (second_p < 0) second_p = idx;
        end
    endtask

    initial begin
        bit bcur, acur, rcur;
        int hold;
        bus.btn = 1'b0; bus.auto_en = 1'b0; rst_n = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("rst_sel", bus.sel, 32'd0);
        check("rst_pulse", bus.sel_pulse, 32'd0);
        check("rst_db", bus.btn_db, 32'd0);

        // Clean press held 20 cycles.
        clear_obs();
        for (int i = 0; i < 20; i++) begin cycle(1'b1, 1'b0, 1'b1); observe(i + 1); end
        check("press_db_cycle", first_db, 32'd7);
        check("press_model_db_cycle", first_mdb, 32'd7);
        check("press_sel_cycle", first_p, 32'd8);
        check("press_pulses", npulse, 32'd1);
        check("press_sel_val", bus.sel, 32'd1);

        clear_obs();
        for (int i = 0; i < 12; i++) begin cycle(1'b0, 1'b0, 1'b1); observe(i + 1); end
        check("release_pulses", npulse, 32'd0);
        check("release_db", bus.btn_db, 32'd0);

        // A 3-cycle glitch must be rejected.
        clear_obs();
        for (int i = 0; i < 18; i++) begin cycle(i < 3, 1'b0, 1'b1); observe(i + 1); end
        check("glitch_pulses", npulse, 32'd0);
        check("glitch_db_seen", first_db, 32'hFFFF_FFFF);

        // Bounce: high 2, low 1, high 10, then low.
        clear_obs();
        for (int i = 0; i < 25; i++) begin cycle((i < 2) || (i >= 3 && i < 13), 1'b0, 1'b1); observe(i + 1); end
        check("bounce_db_cycle", first_db, 32'd10);
        check("bounce_pulses", npulse, 32'd1);

        // Auto toggling from reset release, then switched off.
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        clear_obs();
        for (int i = 0; i < 30; i++) begin cycle(1'b0, 1'b1, 1'b1); observe(i + 1); end
        check("auto_first", first_p, 32'd10);
        check("auto_second", second_p, 32'd18);
        check("auto_pulses", npulse, 32'd3);
        clear_obs();
        for (int i = 0; i < 20; i++) begin cycle(1'b0, 1'b0, 1'b1); observe(i + 1); end
        check("auto_off_pulses", npulse, 32'd0);

        // Button request lands in the auto-wrap cycle.
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        clear_obs();
        for (int i = 0; i < 25; i++) begin cycle(i >= 2, 1'b1, 1'b1); observe(i + 1); end
        check("coll_db_cycle", first_db, 32'd9);
        check("coll_first", first_p, 32'd10);
        check("coll_second", second_p, 32'd18);
        check("coll_pulses", npulse, 32'd2);

        // Reset at debounce count 2 / auto count 6, button held through release.
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        clear_obs();
        for (int i = 0; i < 8; i++) begin cycle(i >= 3, 1'b1, 1'b1); observe(i + 1); end
        check("pre_rst_pulses", npulse, 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        check("midrst_sel", bus.sel, 32'd0);
        check("midrst_db", bus.btn_db, 32'd0);
        clear_obs();
        for (int i = 0; i < 12; i++) begin cycle(1'b1, 1'b1, 1'b1); observe(i + 1); end
        check("midrst_first", first_p, 32'd8);
        check("midrst_pulses", npulse, 32'd1);

        // Randomized run against the model.
        bcur = 1'b0; acur = 1'b0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bcur = ~bcur;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) acur = ~acur;
            rcur = ($urandom_range(0, 149) != 0);
            cycle(bcur, acur, rcur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_ctrl.md
MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter AUTO_PERIOD, default 50000000, meaning cycles between automatic select toggles (0.5 s at 100 MHz).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port btn  input  1  raw pushbutton, asynchronous, bouncing.
REQ-006 The block SHALL have port auto_en  input  1  raw slide switch, asynchronous; 1 = automatic toggling.
REQ-007 The block SHALL have port sel  output  1  registered select; drives the S input of the downstream 2:1 mux (0 = A[0], 1 = A[1]).
REQ-008 The block SHALL have port sel_pulse  output  1  one-cycle strobe, high in the first cycle sel shows a new value.
REQ-009 The block SHALL have port btn_db  output  1  debounced button level.

Function
REQ-010 btn and auto_en SHALL each pass through a 2-flop synchronizer; no other logic SHALL sample the raw inputs.
REQ-011 Debounce FSM states SHALL be STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; btn_db = 1 in STABLE_HI and WAIT_LO, 0 otherwise.
REQ-012 STABLE_LO -> WAIT_HI when synchronized btn = 1; STABLE_HI -> WAIT_LO when synchronized btn = 0; on entry the debounce counter SHALL clear to 0.
REQ-013 In WAIT_x the counter SHALL increment each cycle the synchronized input holds the new level; on reaching DEBOUNCE_CYCLES-1 the FSM SHALL enter the corresponding STABLE state on the next edge.
REQ-014 In WAIT_x, a reversion of the synchronized input SHALL return the FSM to the prior STABLE state with counter cleared and btn_db unchanged (glitch rejected).
REQ-015 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES) bits, minimum 1; it SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-016 A rising edge of btn_db SHALL generate a button toggle request; falling edges SHALL generate nothing.
REQ-017 When synchronized auto_en = 1, the auto counter SHALL increment each cycle, and on reaching AUTO_PERIOD-1 SHALL wrap to 0 and generate an auto toggle request.
REQ-018 When synchronized auto_en = 0, the auto counter SHALL be held at 0 and no auto request generated.
REQ-019 Any toggle request SHALL invert sel on the next edge and assert sel_pulse for exactly that one cycle.
REQ-020 Simultaneous button and auto requests SHALL produce a single inversion, never a double toggle.
REQ-021 A button request SHALL clear the auto counter, so the next auto toggle follows a full AUTO_PERIOD.
REQ-022 Latency: raw btn held high from cycle 0 SHALL give btn_db = 1 at cycle DEBOUNCE_CYCLES+3 and sel toggled at cycle DEBOUNCE_CYCLES+4, with +/-0 cycles.
REQ-023 Holding btn high indefinitely SHALL produce exactly one toggle.

Reset
REQ-024 While rst_n = 0 at a clock edge: sel = 0, sel_pulse = 0, btn_db = 0, FSM = STABLE_LO, both counters = 0, synchronizer flops = 0.
REQ-025 Reset asserted mid-debounce or mid-auto-period SHALL abandon the operation; no toggle SHALL be emitted on or after reset release until a fresh full qualifying interval.
REQ-026 If btn is held high through reset release, it SHALL be debounced as a new press and produce one toggle.

Structure
REQ-027 Debounce state encodings and default parameter values SHALL live in the shared Basys3 constants package/include, reused by other board-input blocks.
REQ-028 The synchronizer plus debounce FSM SHALL be one sub-module, btn_debounce, instantiated once for btn; toggle/auto logic stays in mux_sel_ctrl.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8)
REQ-029 Clean press: btn 0->1 held 20 cycles -> btn_db rises cycle 7, sel 0->1 cycle 8, one sel_pulse, no second toggle.
REQ-030 Bounce: btn high 2 cycles, low 1, high 10 -> single toggle, btn_db rises 4 cycles after last synchronized rise; 3-cycle glitch alone -> no toggle.
REQ-031 Auto: auto_en=1 from reset release -> sel toggles every 8 cycles, sel_pulse each time; auto_en=0 -> toggling stops, counter reads 0.
REQ-032 Collision: button request forced in same cycle as auto wrap -> sel inverts once; next auto toggle 8 cycles later.
REQ-033 Reset mid-operation: rst_n low for 1 cycle at debounce count 2 and auto count 6 -> all outputs 0, no toggle for next 4 (button) / 8 (auto) cycles.
